// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel-rate enable, h/v counters, registered sync/blank/strobes.
// Optional VGA_TIMING_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW     = 10'(H_SYNC);
    localparam logic [9:0] H_AS     = 10'(H_ACT_START);
    localparam logic [9:0] H_AE     = 10'(H_ACT_END);
    localparam logic [9:0] V_SW     = 10'(V_SYNC);
    localparam logic [9:0] V_AS     = 10'(V_ACT_START);
    localparam logic [9:0] V_AE     = 10'(V_ACT_END);

    logic [3:0] div;
    logic [3:0] div_nxt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       line_nxt;
    logic       frame_nxt;

    always_comb begin
        div_nxt   = (div == DIV_LAST) ? 4'd0 : div + 4'd1;
        h_wrap    = (hCount == H_LAST);
        v_wrap    = (vCount == V_LAST);
        h_nxt     = hCount;
        v_nxt     = vCount;
        if (pix_en) begin
            h_nxt = h_wrap ? 10'd0 : hCount + 10'd1;
            if (h_wrap)
                v_nxt = v_wrap ? 10'd0 : vCount + 10'd1;
        end
        line_nxt  = pix_en && h_wrap;
        frame_nxt = line_nxt && v_wrap;
    end

    // Decodes use next-state counters so sync/blank land on the same edge as the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div         <= 4'd0;
            pix_en      <= 1'b0;
            hCount      <= 10'd0;
            vCount      <= 10'd0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            bright      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_en      <= (div_nxt == DIV_LAST);
            hCount      <= h_nxt;
            vCount      <= v_nxt;
            hSync       <= (h_nxt >= H_SW);
            vSync       <= (v_nxt >= V_SW);
            bright      <= (h_nxt >= H_AS) && (h_nxt < H_AE) &&
                           (v_nxt >= V_AS) && (v_nxt < V_AE);
            line_start  <= line_nxt;
            frame_start <= frame_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= 16'd0;
        else if (frame_nxt)
            frame_cnt <= frame_cnt + 16'd1;
    end
`else
    // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 8x4, CLK_DIV=1 instance,
// both checked every cycle against a pixel-count reference model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       pe_d, hs_d, vs_d, br_d, ls_d, fs_d;
    logic [9:0] h_d, v_d;
    logic       pe_s, hs_s, vs_s, br_s, ls_s, fs_s;
    logic [9:0] h_s, v_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    vga_timing_gen dut_d (
        .clk(clk), .rst(rst), .pix_en(pe_d), .hCount(h_d), .vCount(v_d),
        .hSync(hs_d), .vSync(vs_d), .bright(br_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_d)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(8), .H_SYNC(1), .H_ACT_START(2), .H_ACT_END(7),
        .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(3)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pe_s), .hCount(h_s), .vCount(v_s),
        .hSync(hs_s), .vSync(vs_s), .bright(br_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    wire [25:0] obs_d = {pe_d, h_d, v_d, hs_d, vs_d, br_d, ls_d, fs_d};
    wire [25:0] obs_s = {pe_s, h_s, v_s, hs_s, vs_s, br_s, ls_s, fs_s};

    int tests = 0;
    int fails = 0;
    int k = 0;   // clk edges since reset release

    always @(posedge clk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Pixel advances completed after kk edges: first pix_en pulse needs a full divider period.
    function automatic int pix_count(int kk, int d);
        if (kk <= 0) return 0;
        if (d == 1)  return kk - 1;
        return kk / d;
    endfunction

    function automatic logic [25:0] model(int kk, int d, int ht, int hs, int has, int hae,
                                          int vt, int vs, int vas, int vae);
        int n, np, h, v;
        logic pe, br, ls, fs;
        n  = pix_count(kk, d);
        np = pix_count(kk - 1, d);
        h  = n % ht;
        v  = (n / ht) % vt;
        pe = (kk >= 1) && ((kk % d) == d - 1);
        br = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
        ls = (n != np) && (h == 0);
        fs = ls && (v == 0);
        return {pe, 10'(h), 10'(v), (h >= hs), (v >= vs), br, ls, fs};
    endfunction

    function automatic logic [25:0] exp_d(int kk);
        return model(kk, 4, 800, 96, 144, 784, 525, 2, 35, 515);
    endfunction

    function automatic logic [25:0] exp_s(int kk);
        return model(kk, 1, 8, 1, 2, 7, 4, 1, 1, 3);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (obs_d !== 26'd0) begin
            fails++; $display("FAIL reset_default got %h exp %h", obs_d, 26'd0);
        end
        tests++;
        if (obs_s !== 26'd0) begin
            fails++; $display("FAIL reset_small got %h exp %h", obs_s, 26'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            tests++;
            if (obs_d !== exp_d(k)) begin
                fails++; $display("FAIL reset_release_d k=%0d got %h exp %h", k, obs_d, exp_d(k));
            end
            tests++;
            if (obs_s !== exp_s(k)) begin
                fails++; $display("FAIL reset_release_s k=%0d got %h exp %h", k, obs_s, exp_s(k));
            end
            if (i == 3) begin
                tests++;
                if (pe_d !== 1'b1) begin
                    fails++; $display("FAIL first_pix_en got %b exp 1", pe_d);
                end
            end
            if (i == 4) begin
                tests++;
                if ({h_d, hs_d, br_d} !== {10'd1, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL first_pixel got h=%0d hs=%b br=%b exp h=1 hs=0 br=0",
                                      h_d, hs_d, br_d);
                end
            end
        end
    endtask

    task automatic test_line();
        int k1 = -1, k2 = -1, hs_low = 0, ls_high = 0;
        for (int i = 0; i < 10000 && k2 < 0; i++) begin
            @(negedge clk);
            tests++;
            if (obs_d !== exp_d(k)) begin
                fails++; $display("FAIL line_d k=%0d got %h exp %h", k, obs_d, exp_d(k));
            end
            tests++;
            if (obs_s !== exp_s(k)) begin
                fails++; $display("FAIL line_s k=%0d got %h exp %h", k, obs_s, exp_s(k));
            end
            if (ls_d && k1 >= 0) k2 = k;
            else if (ls_d) k1 = k;
            if (k1 >= 0 && k2 < 0) begin
                if (!hs_d) hs_low++;
                if (ls_d)  ls_high++;
            end
        end
        tests++;
        if (k2 - k1 !== 3200) begin
            fails++; $display("FAIL line_period got %0d exp 3200", k2 - k1);
        end
        tests++;
        if (hs_low !== 384) begin
            fails++; $display("FAIL hsync_low_width got %0d exp 384", hs_low);
        end
        tests++;
        if (ls_high !== 1) begin
            fails++; $display("FAIL line_start_width got %0d exp 1", ls_high);
        end
    endtask

    task automatic test_frame_small();
        int last_fs = -1, n_fs = 0, br_cnt = 0, vs_low = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            tests++;
            if (obs_s !== exp_s(k)) begin
                fails++; $display("FAIL frame_s k=%0d got %h exp %h", k, obs_s, exp_s(k));
            end
            if (fs_s) begin
                tests++;
                if (ls_s !== 1'b1) begin
                    fails++; $display("FAIL fs_ls_coincide got %b exp 1", ls_s);
                end
                if (last_fs >= 0) begin
                    tests++;
                    if (k - last_fs !== 32) begin
                        fails++; $display("FAIL frame_period got %0d exp 32", k - last_fs);
                    end
                    tests++;
                    if (br_cnt !== 10) begin
                        fails++; $display("FAIL bright_per_frame got %0d exp 10", br_cnt);
                    end
                    tests++;
                    if (vs_low !== 8) begin
                        fails++; $display("FAIL vsync_low_per_frame got %0d exp 8", vs_low);
                    end
                end
                last_fs = k; n_fs++; br_cnt = 0; vs_low = 0;
            end
            if (br_s)  br_cnt++;
            if (!vs_s) vs_low++;
        end
        tests++;
        if (n_fs < 8) begin
            fails++; $display("FAIL frame_count_seen got %0d exp >=8", n_fs);
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            @(negedge clk);
            tests++;
            if (obs_d !== exp_d(k)) begin
                fails++; $display("FAIL mid_run_d k=%0d got %h exp %h", k, obs_d, exp_d(k));
            end
            if (h_d == 10'd400 && v_d == 10'd2) hit = 1;
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL mid_reset_target got h=%0d v=%0d exp h=400 v=2", h_d, v_d);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs_d !== 26'd0) begin
            fails++; $display("FAIL async_reset_d got %h exp %h", obs_d, 26'd0);
        end
        tests++;
        if (obs_s !== 26'd0) begin
            fails++; $display("FAIL async_reset_s got %h exp %h", obs_s, 26'd0);
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            tests++;
            if (obs_d !== exp_d(k)) begin
                fails++; $display("FAIL restart_d k=%0d got %h exp %h", k, obs_d, exp_d(k));
            end
            tests++;
            if (obs_s !== exp_s(k)) begin
                fails++; $display("FAIL restart_s k=%0d got %h exp %h", k, obs_s, exp_s(k));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int run_len = $urandom_range(50, 2500);
            @(negedge clk);
            #($urandom_range(1, 4)) rst = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < run_len; i++) begin
                @(negedge clk);
                tests++;
                if (obs_d !== exp_d(k)) begin
                    fails++; $display("FAIL random_d it=%0d k=%0d got %h exp %h", it, k, obs_d, exp_d(k));
                end
                tests++;
                if (obs_s !== exp_s(k)) begin
                    fails++; $display("FAIL random_s it=%0d k=%0d got %h exp %h", it, k, obs_s, exp_s(k));
                end
            end
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            tests++;
            if (fc_s !== 16'(pix_count(k, 1) / 32)) begin
                fails++; $display("FAIL frame_cnt_s k=%0d got %0d exp %0d", k, fc_s, pix_count(k, 1) / 32);
            end
            tests++;
            if (fc_d !== 16'(pix_count(k, 4) / 420000)) begin
                fails++; $display("FAIL frame_cnt_d k=%0d got %0d exp 0", k, fc_d);
            end
        end
        for (int i = 0; i < 100 && !fs_s; i++) @(negedge clk);
        force dut_s.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_s.frame_cnt;
        for (int f = 0; f < 2; f++) begin
            bit got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                if (fs_s) got = 1;
            end
            tests++;
            if (!got) begin
                fails++; $display("FAIL frame_cnt_wait got no frame_start exp one within 100 clks");
            end
            tests++;
            if (fc_s !== 16'(f)) begin
                fails++; $display("FAIL frame_cnt_wrap f=%0d got %h exp %h", f, fc_s, 16'(f));
            end
            seen++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line();
        test_frame_small();
        test_mid_reset();
        test_random();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
